// File: rtl/cache_pkg.sv
// Shared cache-hierarchy definitions: trace command codes and common widths.
package cache_pkg;

    typedef enum logic [3:0] {
        CMD_READ       = 4'd0,
        CMD_WRITE      = 4'd1,
        CMD_INVALIDATE = 4'd3,
        CMD_RESET      = 4'd8,
        CMD_PRINT      = 4'd9
    } cmd_e;

    localparam int LINE_ADDR_W = 26;
    localparam int STAT_W      = 32;

endpackage

// File: rtl/req_fifo_ram.sv
// Storage array for the L2 request queue: one write port, one asynchronous read port.
module req_fifo_ram #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 26
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ADDR_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ADDR_W-1:0]        rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    // Data array carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/l2_req_queue.sv
// L1-to-L2 line-address request FIFO with req/ack issue and issue/drop statistics.
// Optional COALESCE_EN merges a beat matching the most recently pushed resident entry.
module l2_req_queue
    import cache_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int CNT_W  = STAT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             n,
    input  logic                   in_valid,
    input  logic [ADDR_W-1:0]      in_add,
    output logic                   out_req,
    output logic [ADDR_W-1:0]      out_add,
    input  logic                   out_ack,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       issued,
    output logic [CNT_W-1:0]       dropped,
    output logic [CNT_W-1:0]       coalesced
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]       wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] rd_data;
    logic              clr, pop, push, drop, merge;

    assign clr   = rst || (n == CMD_RESET);
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    // Stale array contents are masked so an empty queue always presents address 0.
    assign out_req = !empty;
    assign out_add = empty ? '0 : rd_data;

    assign pop  = !clr && out_req && out_ack;
    assign push = !clr && in_valid && !merge && (!full || pop);
    assign drop = !clr && in_valid && !merge && full && !pop;

    req_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[PW-1:0]),
        .wdata (in_add),
        .raddr (rd_ptr[PW-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            issued  <= '0;
            dropped <= '0;
        end else begin
            if (push) wr_ptr  <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr  <= rd_ptr + (PW+1)'(1);
            if (pop)  issued  <= issued + CNT_W'(1);
            if (drop) dropped <= dropped + CNT_W'(1);
        end
    end

`ifdef COALESCE_EN
    logic              last_vld;
    logic [ADDR_W-1:0] last_add;
    logic              last_popped;

    // The newest entry leaves the queue only when it is also the oldest one.
    assign last_popped = pop && (count == (PW+1)'(1));
    assign merge       = !clr && in_valid && last_vld && (in_add == last_add) && !last_popped;

    always_ff @(posedge clk) begin
        if (clr) begin
            last_vld  <= 1'b0;
            coalesced <= '0;
        end else begin
            if (push)             last_vld <= 1'b1;
            else if (last_popped) last_vld <= 1'b0;
            if (merge) coalesced <= coalesced + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) last_add <= in_add;
    end
`else
    assign merge     = 1'b0;
    assign coalesced = '0;
`endif

endmodule

// File: tb/tb_l2_req_queue.sv
// Directed bench for l2_req_queue with a queue-based reference model checked every cycle.
module tb_l2_req_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 26;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    n;
    logic          in_valid;
    logic [AW-1:0] in_add;
    logic          out_req;
    logic [AW-1:0] out_add;
    logic          out_ack;
    logic          full, empty;
    logic [3:0]    count;
    logic [CW-1:0] issued, dropped, coalesced;

    l2_req_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .n(n), .in_valid(in_valid), .in_add(in_add),
        .out_req(out_req), .out_add(out_add), .out_ack(out_ack),
        .full(full), .empty(empty), .count(count),
        .issued(issued), .dropped(dropped), .coalesced(coalesced)
    );

    always #5 clk = ~clk;

`ifdef COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [AW-1:0] mq[$];
    longint m_issued, m_dropped, m_coal;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what the queue must hold after this edge given current inputs.
    task automatic model_step();
        int  sz;
        bit  pop, mrg;
        if (rst || n == 4'd8) begin
            mq.delete();
            m_issued = 0; m_dropped = 0; m_coal = 0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && out_ack;
            mrg = COAL && in_valid && (sz > 0) && (in_add == mq[sz-1]) && !(pop && sz == 1);
            if (pop) begin
                void'(mq.pop_front());
                m_issued = (m_issued + 1) % (64'd1 << CW);
            end
            if (mrg) m_coal++;
            else if (in_valid) begin
                if (sz < DEPTH || pop) mq.push_back(in_add);
                else m_dropped++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_req",   out_req,   mq.size() != 0);
            if (mq.size() != 0) chk("out_add", out_add, mq[0]);
            else                chk("out_add", out_add, 0);
            chk("count",     count,     mq.size());
            chk("full",      full,      mq.size() == DEPTH);
            chk("empty",     empty,     mq.size() == 0);
            chk("issued",    issued,    m_issued);
            chk("dropped",   dropped,   m_dropped);
            chk("coalesced", coalesced, m_coal);
        end
    end

    task automatic cyc(input logic r, input logic v, input logic [AW-1:0] a,
                       input logic ack, input logic [3:0] cmd);
        rst = r; in_valid = v; in_add = a; out_ack = ack; n = cmd;
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int pcnt, popn, guard;
        logic [AW-1:0] exp_a;
        rst = 1'b1; n = 4'd0; in_valid = 1'b0; in_add = '0; out_ack = 1'b0;
        cyc(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        cyc(1, 1, 26'h155, 1, 0);
        chk("rst_empty",   empty,   1);
        chk("rst_count",   count,   0);
        chk("rst_out_req", out_req, 0);
        chk("rst_out_add", out_add, 0);
        chk("rst_issued",  issued,  0);

        // basic transfer
        cyc(0, 1, 26'h0ABCDEF, 0, 0);
        chk("basic_req", out_req, 1);
        chk("basic_add", out_add, 26'h0ABCDEF);
        cyc(0, 0, 0, 1, 0);
        chk("basic_empty",  empty,  1);
        chk("basic_issued", issued, 1);
        cyc(0, 0, 0, 1, 0);
        chk("basic_ack_empty_ignored", issued, 1);

        // backpressure
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, AW'(32'h10 + i), 0, 0);
        chk("bp_full",  full,  1);
        chk("bp_count", count, 8);
        cyc(0, 1, 26'h18, 0, 0);
        chk("bp_dropped", dropped, 1);
        chk("bp_hold",    out_add, 26'h10);
        for (int i = 0; i < 8; i++) begin
            chk("bp_order", out_add, AW'(32'h10 + i));
            cyc(0, 0, 0, 1, 0);
        end
        chk("bp_issued", issued, 8);

        // simultaneous push/pop at full
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, AW'(32'h40 + i), 0, 0);
        cyc(0, 1, 26'h20, 1, 0);
        chk("fullpp_count",   count,   8);
        chk("fullpp_dropped", dropped, 0);
        for (int i = 0; i < 8; i++) begin
            exp_a = (i == 7) ? 26'h20 : AW'(32'h41 + i);
            chk("fullpp_order", out_add, exp_a);
            cyc(0, 0, 0, 1, 0);
        end

        // RESET command mid-operation
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, AW'(32'h50 + i), 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("cmdrst_pre_issued", issued, 1);
        chk("cmdrst_pre_count",  count,  5);
        cyc(0, 1, 26'h77, 1, 4'd8);
        chk("cmdrst_empty",   empty,   1);
        chk("cmdrst_req",     out_req, 0);
        chk("cmdrst_issued",  issued,  0);
        chk("cmdrst_dropped", dropped, 0);

        // coalescing
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 26'h30, 0, 0);
        cyc(0, 1, 26'h30, 0, 0);
        cyc(0, 1, 26'h31, 0, 0);
        cyc(0, 1, 26'h30, 0, 4'd1);
        chk("coal_count", count,     COAL ? 3 : 4);
        chk("coal_cnt",   coalesced, COAL ? 1 : 0);
        while (mq.size() != 0) cyc(0, 0, 0, 1, 4'd9);

        // wrap-around with random ack gaps
        cyc(1, 0, 0, 0, 0);
        pcnt = 0; popn = 0; guard = 0;
        while (popn < 3*DEPTH+3 && guard < 600) begin
            logic v, ack;
            v   = (pcnt < 3*DEPTH+3) && (mq.size() < DEPTH);
            ack = ($urandom_range(0, 2) != 0);
            if (ack && mq.size() != 0) begin
                chk("wrap_order", out_add, AW'(32'h100 + popn));
                popn++;
            end
            cyc(0, v, AW'(32'h100 + pcnt), ack, 4'd3);
            if (v) pcnt++;
            guard++;
        end
        chk("wrap_issued",  issued,  27);
        chk("wrap_dropped", dropped, 0);
        chk("wrap_empty",   empty,   1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
